// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ write-domain requesters.
// Build option FIFO_WR_ARB_STALL_CNT_EN adds a saturating full-stall cycle counter on stall_cnt.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     w_clk,
  input  logic                     w_rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     fifo_w_en,
  output logic [DW-1:0]            fifo_w_data,
  input  logic                     fifo_full,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [15:0]              stall_cnt
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);
  localparam logic [BW-1:0] CAP_M1  = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_sel;
  logic [IW-1:0] cand;
  logic [BW-1:0] beat_cnt;
  logic          any_vld;
  logic          gnt_vld;
  logic          xfer;
  logic          burst_end;
  int            idx;

  // Descending scan so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    any_vld = 1'b0;
    rr_sel  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx  = (int'(rr_ptr) + k) % N_REQ;
      cand = IW'(idx);
      if (req_valid[cand]) begin
        any_vld = 1'b1;
        rr_sel  = cand;
      end
    end
  end

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (busy && grant_id == IW'(i)) fifo_w_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = !fifo_full;
  end

  assign gnt_vld   = busy && req_valid[grant_id];
  assign xfer      = gnt_vld && !fifo_full;
  assign fifo_w_en = xfer;
  assign burst_end = xfer && (req_last[grant_id] || beat_cnt == CAP_M1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            state    <= GRANT;
            busy     <= 1'b1;
            grant_id <= rr_sel;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + BW'(1);
          if (burst_end) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (gnt_vld && fifo_full && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT, a scoreboard checks FIFO writes.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int N_REQ = 4;
  localparam int MAX_BURST = 4;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd5;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic                w_clk;
  logic                w_rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_w_en;
  logic [DW-1:0]       fifo_w_data;
  logic                fifo_full;
  logic [1:0]          grant_id;
  logic                busy;
  logic [15:0]         stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW:0]   rq [N_REQ][$];
  logic [DW-1:0] exp_q [$];

  fifo_wr_arbiter #(.DW(DW), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge w_clk);
    #3;
  endtask

  task automatic push(input int id, input logic last, input logic [DW-1:0] d, input bit expect_wr);
    rq[id].push_back({last, d});
    if (expect_wr) exp_q.push_back(d);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Requester model: pops a beat after each accepted handshake, presents the queue head.
  initial begin
    logic [N_REQ-1:0] acc;
    logic [DW:0]      e;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge w_clk);
      acc = req_valid & req_ready;
      @(posedge w_clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          e = rq[i][0];
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = e[DW-1:0];
          req_last[i] = e[DW];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every FIFO write must match the next expected beat.
  initial begin
    forever begin
      @(negedge w_clk);
      if (fifo_w_en) begin
        if (exp_q.size() == 0) check("unexpected_write", {24'h0, fifo_w_data}, 32'hFFFF_FFFF);
        else check("wdata", fifo_w_data, exp_q.pop_front());
        check("write_while_full", fifo_full, 0);
      end
    end
  end

  initial begin
    logic [9:0] pat;
    w_rst_n   = 1'b0;
    fifo_full = 1'b0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_w_en", fifo_w_en, 0);
    check("rst_w_data", fifo_w_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    w_rst_n = 1'b1;
    tick(1);

    // Single 3-beat burst from requester 2.
    push(2, 1'b0, 8'hA0, 1'b1);
    push(2, 1'b0, 8'hA1, 1'b1);
    push(2, 1'b1, 8'hA2, 1'b1);
    tick(1);
    check("single_arb_idle", busy, 0);
    tick(1);
    check("single_busy", busy, 1);
    check("single_grant", grant_id, 2);
    check("single_ready", req_ready, 4'b0100);
    check("single_w_en0", fifo_w_en, 1);
    tick(1);
    check("single_w_en1", fifo_w_en, 1);
    tick(1);
    check("single_w_en2", fifo_w_en, 1);
    tick(1);
    check("single_done_busy", busy, 0);
    check("single_done_w_en", fifo_w_en, 0);

    // Wrap-around: rr_ptr=3, only requester 0 valid.
    push(0, 1'b1, 8'h01, 1'b1);
    tick(2);
    check("wrap_grant", grant_id, 0);
    check("wrap_busy", busy, 1);
    tick(1);
    check("wrap_done", busy, 0);

    // All four valid with single-beat bursts; rr_ptr=1 so order is 1,2,3,0,1.
    push(1, 1'b1, 8'h11, 1'b1);
    push(2, 1'b1, 8'h12, 1'b1);
    push(3, 1'b1, 8'h13, 1'b1);
    push(0, 1'b1, 8'h10, 1'b1);
    push(1, 1'b1, 8'h15, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pat[i] = fifo_w_en;
    end
    check("rr_bubble_pattern", pat, 10'b1010101010);
    tick(1);
    check("rr_done", busy, 0);

    // MAX_BURST cap: requester 1 streams 8 beats without last, requester 3 cuts in.
    for (int j = 0; j < 8; j++) begin
      if (j < 4) push(1, 1'b0, 8'h80 + 8'(j), 1'b1);
      else push(1, 1'b0, 8'h80 + 8'(j), 1'b0);
    end
    tick(2);
    check("cap_grant1", grant_id, 1);
    push(3, 1'b1, 8'h3A, 1'b1);
    for (int j = 4; j < 8; j++) exp_q.push_back(8'h80 + 8'(j));
    tick(4);
    check("cap_end_idle", busy, 0);
    tick(1);
    check("cap_next_grant", grant_id, 3);
    check("cap_next_busy", busy, 1);
    tick(6);
    check("cap_regrant_done", busy, 0);
    check("cap_all_written", exp_q.size(), 0);

    // Full stall of 5 cycles after the first beat of a 4-beat capped burst.
    for (int j = 0; j < 4; j++) push(2, 1'b0, 8'hC0 + 8'(j), 1'b1);
    tick(2);
    check("stall_grant", grant_id, 2);
    check("stall_first_w_en", fifo_w_en, 1);
    tick(1);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_ready", req_ready, 0);
      check("stall_w_en", fifo_w_en, 0);
      tick(1);
    end
    fifo_full = 1'b0;
    tick(2);
    check("stall_cnt_held", busy, 1);
    tick(1);
    check("stall_burst_done", busy, 0);
    check("stall_cnt", stall_cnt, STALL_EXP);
    check("stall_all_written", exp_q.size(), 0);

    // Reset during beat 2 of a burst from requester 3.
    push(3, 1'b0, 8'h50, 1'b1);
    push(3, 1'b0, 8'h51, 1'b0);
    push(3, 1'b0, 8'h52, 1'b0);
    push(3, 1'b1, 8'h53, 1'b0);
    tick(2);
    check("rstmid_grant", grant_id, 3);
    tick(1);
    w_rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_grant_id", grant_id, 0);
    check("rstmid_ready", req_ready, 0);
    check("rstmid_w_en", fifo_w_en, 0);
    check("rstmid_w_data", fifo_w_data, 0);
    check("rstmid_stall_cnt", stall_cnt, 0);
    rq[3].delete();
    tick(1);
    w_rst_n = 1'b1;
    push(1, 1'b1, 8'h61, 1'b1);
    push(3, 1'b1, 8'h63, 1'b1);
    tick(2);
    check("post_rst_grant", grant_id, 1);
    drain(20);
    tick(2);
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    check("timeout", 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "FAIL timeout: simulation did not complete");
  end
endmodule
